// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   MEM_LAST    : highest valid byte address of the data memory
//   F3_*        : RISC-V load/store width codes
//   state_e     : controller state encoding
//   rmw_lat_t   : latched sub-word store (address, width, merged word)
//   access_size : byte count of an access for a given width code
package lsu_pkg;

    localparam int unsigned MEM_LAST = 4096;
    localparam int unsigned XLEN     = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_DONE = 2'd1,
        ST_RMW_WR    = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [2:0]      funct3;
        logic [XLEN-1:0] word;
    } rmw_lat_t;

    // Undefined codes report 4 bytes; they are rejected before use anyway.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extraction for a big-endian memory word.
//   funct3 : in  width code of the load
//   word   : in  32-bit word read at the load address (addressed byte in [31:24])
//   ext_c  : out right-aligned, sign- or zero-extended load result
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] ext_c
);

    // The addressed byte/halfword is always the most significant part of the word.
    always_comb begin
        ext_c = word;
        case (funct3)
            F3_B:    ext_c = {{24{word[31]}}, word[31:24]};
            F3_BU:   ext_c = {24'h000000, word[31:24]};
            F3_H:    ext_c = {{16{word[31]}}, word[31:16]};
            F3_HU:   ext_c = {16'h0000, word[31:16]};
            default: ext_c = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a big-endian data memory
// with combinational read and synchronous 32-bit write.
//   clock, reset        : clock and synchronous active-high reset
//   req_valid/we/funct3 : MEM-stage request, held stable until busy drops
//   req_addr/req_wdata  : byte address and right-aligned store data
//   busy, done, err     : stall, completion pulse, rejected-access flag
//   rdata               : registered load result
//   mem_value/esc/read/addr : memory write data, write enable, read enable, address
//   mem_rdata           : combinational memory read word
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_value,
    output logic        mem_esc,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    rmw_lat_t        rmw_q, rmw_d;

    logic [XLEN:0]   end_addr;
    logic            f3_valid;
    logic            illegal;
    logic            is_sw;
    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] load_ext;

    // Request decode: last byte touched, computed one bit wider so no wrap.
    assign end_addr = {1'b0, req_addr} + (XLEN+1)'(access_size(req_funct3)) - (XLEN+1)'(1);
    assign f3_valid = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                      (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    assign illegal  = !f3_valid || (req_we && req_funct3[2]) ||
                      (end_addr > (XLEN+1)'(MEM_LAST));
    assign is_sw    = req_we && (req_funct3 == F3_W);

    // Sub-word store merge: new data replaces the addressed (most significant) bytes.
    assign merged = (req_funct3 == F3_B) ? {req_wdata[7:0],  mem_rdata[23:0]}
                                         : {req_wdata[15:0], mem_rdata[15:0]};

    lsu_extend u_extend (
        .funct3 (req_funct3),
        .word   (mem_rdata),
        .ext_c  (load_ext)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            rmw_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            rmw_q   <= rmw_d;
        end
    end

    // Next state plus the load result and store latches.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rmw_d   = rmw_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        rdata_d = '0;
                    end else if (!req_we) begin
                        rdata_d = load_ext;
                        state_d = ST_LOAD_DONE;
                    end else if (!is_sw) begin
                        rmw_d.addr   = req_addr;
                        rmw_d.funct3 = req_funct3;
                        rmw_d.word   = merged;
                        state_d      = ST_RMW_WR;
                    end
                end
            end
            ST_LOAD_DONE: state_d = ST_IDLE;
            ST_RMW_WR:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs; reset forces everything quiet, which also suppresses a pending RMW write.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_value = '0;
        mem_esc   = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            done = 1'b1;
                            err  = 1'b1;
                        end else if (is_sw) begin
                            mem_esc   = 1'b1;
                            mem_addr  = req_addr;
                            mem_value = req_wdata;
                            done      = 1'b1;
                        end else begin
                            mem_read = 1'b1;
                            mem_addr = req_addr;
                            busy     = 1'b1;
                        end
                    end
                end
                ST_LOAD_DONE: done = 1'b1;
                ST_RMW_WR: begin
                    // Only byte/halfword stores ever reach this state; write only for those.
                    mem_esc   = (rmw_q.funct3 == F3_B) || (rmw_q.funct3 == F3_H);
                    mem_addr  = rmw_q.addr;
                    mem_value = rmw_q.word;
                    done      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a behavioural big-endian data memory.
module tb_lsu_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] mem_value;
    logic        mem_esc, mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    lsu_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_value  (mem_value),
        .mem_esc    (mem_esc),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: 4097 valid bytes plus padding so word accesses at the top stay in bounds.
    logic [7:0] mem [0:4103];
    logic       mem_init = 1'b0;

    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 4104; i++) mem[i] <= 8'h00;
            mem[3]   <= 8'h01;
            mem[7]   <= 8'h02;
            mem[11]  <= 8'h05;
            mem[15]  <= 8'h04;
            mem_init <= 1'b1;
        end else if (mem_esc && mem_addr <= 32'd4100) begin
            mem[mem_addr]      <= mem_value[31:24];
            mem[mem_addr + 1]  <= mem_value[23:16];
            mem[mem_addr + 2]  <= mem_value[15:8];
            mem[mem_addr + 3]  <= mem_value[7:0];
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr <= 32'd4100)
            mem_rdata = {mem[mem_addr], mem[mem_addr + 1], mem[mem_addr + 2], mem[mem_addr + 3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Read and write strobes must never overlap.
    always @(negedge clock) begin
        if (mem_esc || mem_read)
            check("esc_read_overlap", 32'(mem_esc && mem_read), 32'd0);
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        string       name;
        logic        is_load;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    // Drive one request (inputs change #1 after posedge), score it when done appears.
    task automatic run_req(input vec_t v);
        exp_t e;
        int   cyc;
        int   n_esc;
        int   n_read;
        bit   seen;
        int   exp_esc;
        int   exp_read;
        sb_q.push_back('{v.name, !v.we, v.exp_err, v.exp_lat, v.exp_rdata});
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        cyc = 0; n_esc = 0; n_read = 0; seen = 0;
        while (!seen && cyc < 4) begin
            @(negedge clock);
            cyc++;
            if (mem_esc) begin
                n_esc++;
                check({v.name, "_esc_addr"}, mem_addr, v.addr);
                if (v.f3 == 3'b010) check({v.name, "_esc_value"}, mem_value, v.wdata);
            end
            if (mem_read) begin
                n_read++;
                check({v.name, "_read_addr"}, mem_addr, v.addr);
            end
            if (done) begin
                seen = 1;
                e = sb_q.pop_front();
                check({e.name, "_latency"}, 32'(cyc), 32'(e.exp_lat));
                check({e.name, "_err"}, 32'(err), 32'(e.exp_err));
                check({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
                if (e.is_load && !e.exp_err) check({e.name, "_rdata"}, rdata, e.exp_rdata);
            end else begin
                check({v.name, "_busy_stall"}, 32'(busy), 32'd1);
            end
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 4 cycles", v.name);
            void'(sb_q.pop_front());
        end
        exp_esc  = (v.we && !v.exp_err) ? 1 : 0;
        exp_read = (!v.exp_err && !(v.we && v.f3 == 3'b010)) ? 1 : 0;
        check({v.name, "_esc_cycles"}, 32'(n_esc), 32'(exp_esc));
        check({v.name, "_read_cycles"}, 32'(n_read), 32'(exp_read));
        if (v.exp_err) begin
            @(negedge clock);
            check({v.name, "_err_rdata"}, rdata, 32'h0);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_esc"}, 32'(mem_esc), 32'd0);
        check({name, "_read"}, 32'(mem_read), 32'd0);
        check({name, "_addr"}, mem_addr, 32'h0);
        check({name, "_value"}, mem_value, 32'h0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;

        //               name        we  f3      addr   wdata         err lat rdata
        vecs.push_back('{"lw8",      0, 3'b010, 32'd8,    32'h0,        0, 2, 32'h00000005});
        vecs.push_back('{"sb0",      1, 3'b000, 32'd0,    32'h000000F0, 0, 2, 32'h0});
        vecs.push_back('{"lb0",      0, 3'b000, 32'd0,    32'h0,        0, 2, 32'hFFFFFFF0});
        vecs.push_back('{"lbu0",     0, 3'b100, 32'd0,    32'h0,        0, 2, 32'h000000F0});
        vecs.push_back('{"lw0",      0, 3'b010, 32'd0,    32'h0,        0, 2, 32'hF0000001});
        vecs.push_back('{"lh2",      0, 3'b001, 32'd2,    32'h0,        0, 2, 32'h00000001});
        vecs.push_back('{"sh12",     1, 3'b001, 32'd12,   32'hABCD1234, 0, 2, 32'h0});
        vecs.push_back('{"lw12",     0, 3'b010, 32'd12,   32'h0,        0, 2, 32'h12340004});
        vecs.push_back('{"lhu12",    0, 3'b101, 32'd12,   32'h0,        0, 2, 32'h00001234});
        vecs.push_back('{"lh14",     0, 3'b001, 32'd14,   32'h0,        0, 2, 32'h00000004});
        vecs.push_back('{"sw4",      1, 3'b010, 32'd4,    32'hDEADBEEF, 0, 1, 32'h0});
        vecs.push_back('{"lw4",      0, 3'b010, 32'd4,    32'h0,        0, 2, 32'hDEADBEEF});
        vecs.push_back('{"lb5",      0, 3'b000, 32'd5,    32'h0,        0, 2, 32'hFFFFFFAD});
        vecs.push_back('{"lh4",      0, 3'b001, 32'd4,    32'h0,        0, 2, 32'hFFFFDEAD});
        vecs.push_back('{"lhu4",     0, 3'b101, 32'd4,    32'h0,        0, 2, 32'h0000DEAD});
        vecs.push_back('{"lw4094",   0, 3'b010, 32'd4094, 32'h0,        1, 1, 32'h0});
        vecs.push_back('{"lh4096",   0, 3'b001, 32'd4096, 32'h0,        1, 1, 32'h0});
        vecs.push_back('{"f3_011",   0, 3'b011, 32'd0,    32'h0,        1, 1, 32'h0});
        vecs.push_back('{"f3_111",   0, 3'b111, 32'd0,    32'h0,        1, 1, 32'h0});
        vecs.push_back('{"sbu_st",   1, 3'b100, 32'd0,    32'h0,        1, 1, 32'h0});
        vecs.push_back('{"sw_wrap",  1, 3'b010, 32'hFFFFFFFE, 32'h1,    1, 1, 32'h0});
        vecs.push_back('{"sb4096",   1, 3'b000, 32'd4096, 32'h0000005A, 0, 2, 32'h0});
        vecs.push_back('{"lbu4096",  0, 3'b100, 32'd4096, 32'h0,        0, 2, 32'h0000005A});
        vecs.push_back('{"lw4093",   0, 3'b010, 32'd4093, 32'h0,        0, 2, 32'h0000005A});
        vecs.push_back('{"lw0_after",0, 3'b010, 32'd0,    32'h0,        0, 2, 32'hF0000001});

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check_quiet("reset_held");
        check("reset_rdata", rdata, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_quiet("after_reset");
        check("after_reset_rdata", rdata, 32'h0);
        @(posedge clock);
        #1;

        foreach (vecs[i]) run_req(vecs[i]);

        // rdata holds in IDLE with no request.
        @(negedge clock);
        check("rdata_hold", rdata, 32'hF0000001);
        check_quiet("idle_no_req");
        @(posedge clock);
        #1;

        // req_valid dropping in LOAD_DONE does not abort the load.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd12;
        @(negedge clock);
        check("drop_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("drop_done", 32'(done), 32'd1);
        check("drop_rdata", rdata, 32'h12340004);
        @(posedge clock);
        #1;

        // req_valid dropping in RMW_WR still writes the latched word.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'd13; req_wdata = 32'h0000009C;
        @(posedge clock);
        #1 req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'h0;
        @(negedge clock);
        check("rmw_drop_esc", 32'(mem_esc), 32'd1);
        check("rmw_drop_addr", mem_addr, 32'd13);
        check("rmw_drop_value", mem_value, 32'h9C000400);
        @(posedge clock);
        #1;
        run_req('{"lw12_b", 0, 3'b010, 32'd12, 32'h0, 0, 2, 32'h129C0004});

        // Reset in the RMW_WR cycle suppresses the write.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'd8; req_wdata = 32'h00000077;
        @(negedge clock);
        check("rst_rmw_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_rmw_esc", 32'(mem_esc), 32'd0);
        check("rst_rmw_done", 32'(done), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        check_quiet("post_rst_rmw");
        check("post_rst_rdata", rdata, 32'h0);
        @(posedge clock);
        #1;
        run_req('{"lw8_kept", 0, 3'b010, 32'd8, 32'h0, 0, 2, 32'h00000005});

        // Reset in IDLE with a load pending drops it: no done then or after.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd4; reset = 1'b1;
        @(negedge clock);
        check("rst_idle_done", 32'(done), 32'd0);
        check("rst_idle_read", 32'(mem_read), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        check_quiet("post_rst_idle");
        @(posedge clock);
        #1;

        // Reset in LOAD_DONE: no done is issued.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd4;
        @(posedge clock);
        #1 reset = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        check("rst_ld_done", 32'(done), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_quiet("post_rst_ld");
        @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the pipeline MEM stage and the byte-addressed, big-endian data memory. The data memory has a combinational read and a synchronous 32-bit write. This block drives the memory's `value`/`esc_mem`/`read_mem`/`dst_mem` inputs and consumes `out_dat`. It adds RISC-V byte/halfword loads with sign/zero extension, sub-word stores by read-modify-write, range checking, and a `busy` stall to the pipeline.

## Interface
- `MEM_LAST`, 4096: highest valid byte address of the data memory.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  MEM-stage access present; held with its fields stable until `busy`=0.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `busy`  out  1  pipeline must stall this cycle.
- `done`  out  1  one-cycle pulse: access completes this cycle.
- `err`  out  1  with `done`: range or funct3 violation, no memory access made.
- `rdata`  out  32  load result, valid when `done` & !`err` & load.
- `mem_value`  out  32  to memory `value`.
- `mem_esc`  out  1  to memory `esc_mem`.
- `mem_read`  out  1  to memory `read_mem`.
- `mem_addr`  out  32  to memory `dst_mem`.
- `mem_rdata`  in  32  from memory `out_dat`; combinational, `{dat[a],dat[a+1],dat[a+2],dat[a+3]}`.

## Operation
- States: IDLE, LOAD_DONE, RMW_WR.
- IDLE, `req_valid`=0: all outputs 0; `rdata` holds its last value.
- IDLE, illegal request (invalid funct3; store with funct3 1xx; `req_addr`+size−1 > `MEM_LAST`, size 1/2/4; 32-bit compare with no wrap): `done`=`err`=1, `busy`=0, no `mem_*` activity, `rdata`←0. Stay in IDLE.
- IDLE, SW: `mem_esc`=1, `mem_addr`=`req_addr`, `mem_value`=`req_wdata`, `done`=1, `busy`=0. Stay in IDLE.
- IDLE, load: `mem_read`=1, `mem_addr`=`req_addr`, `busy`=1. Register the extended result.
  - W: `mem_rdata`.
  - H/HU: `mem_rdata[31:16]` sign- or zero-extended.
  - B/BU: `mem_rdata[31:24]` sign- or zero-extended.
  - Go to LOAD_DONE.
- LOAD_DONE: `done`=1, `busy`=0, `rdata`=registered value. Go to IDLE.
- IDLE, SB/SH: `mem_read`=1, `busy`=1. Latch `req_addr`, funct3, and the merged word.
  - SB: `{req_wdata[7:0], mem_rdata[23:0]}`.
  - SH: `{req_wdata[15:0], mem_rdata[15:0]}`.
  - Go to RMW_WR.
- RMW_WR: `mem_esc`=1, `mem_addr`/`mem_value` from latches (the live request fields are ignored), `done`=1, `busy`=0. Go to IDLE.
- `mem_esc` and `mem_read` are never both 1 in the same cycle.

## Timing
- Reset: state IDLE; `rdata`, latches, `busy`, `done`, `err`, `mem_esc`, `mem_read`, `mem_addr`, `mem_value` all 0.
- Latency: SW and errors take 1 cycle; loads, SB and SH take 2 cycles (1 stall).
- Memory write commits on the rising edge ending the `mem_esc` cycle. A load issued the following cycle sees the new data.
- `busy`, `done`, `err` and the `mem_*` outputs are combinational from the state and request. `rdata` and the latches are registered.
- Reset in IDLE with a load or SB/SH pending: the access is dropped and no `done` is issued.
- Reset during LOAD_DONE or RMW_WR: next state IDLE, no further `done`. A write already presented in RMW_WR is suppressed (reset wins over `mem_esc`).
- `req_valid` deasserting in LOAD_DONE or RMW_WR does not abort the access. The latched access completes.
- Back-to-back requests: the new request is decoded in the cycle after `done`.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants F3_B/H/W/BU/HU.
  - state enum.
  - function `access_size(funct3)` returning 1/2/4.
- Sub-module `lsu_extend`: combinational load extraction and sign/zero extension from (funct3, 32-bit word).
- The top level holds the FSM, range check, RMW merge and latches.

## Test plan
- Memory words preloaded 0x00000001 @0, 0x00000002 @4, 0x00000005 @8, 0x00000004 @12. LW 8 → `busy`=1 for 1 cycle, then `done`=1, `rdata`=0x00000005.
- SB 0 with `req_wdata`=0x000000F0, then LB 0 → 0xFFFFFFF0; LBU 0 → 0x000000F0; bytes 1..3 unchanged (word 0xF0000001).
- SH 12 with `req_wdata`=0xABCD1234 → word @12 = 0x12340004. `mem_esc` high exactly 1 cycle, never overlapping `mem_read`. LHU 12 → 0x00001234.
- SW 4 with 0xDEADBEEF, `done` with no stall; the next-cycle LW 4 → 0xDEADBEEF.
- LW 4094, LH 4096, and funct3 011 → each gives `done`=`err`=1, `rdata`=0, no `mem_read`/`mem_esc`.
- SB 8 with `reset` asserted in the RMW_WR cycle → no write (word @8 stays 0x00000005), state IDLE, all outputs 0 next cycle.
